// File: rtl/imm_gen_stage.sv
// Purpose : RISC-V immediate generator with a registered valid/ready output stage and skid buffer.
// Latency : 1 cycle from input transfer to out_valid when the stage is empty; 1 instr/cycle sustained.
// Backpr. : in_ready is registered (low only while the skid entry is occupied); output held stable while stalled.
//
// Ports   : clk, rst (sync, active-high), flush (drops held entries and the same-cycle input)
//           in_valid/in_ready/in_instr   upstream handshake + raw 32-bit instruction
//           out_valid/out_ready          downstream handshake
//           out_imm[XLEN], out_fmt[3], out_illegal, illegal_cnt[CNT_W] (saturating)
// Option  : define IMM_GEN_ZICSR_EN to decode csrr*i as format Z (zero-extended zimm in i[19:15]).
module imm_gen_stage #(
    parameter int XLEN  = 32,   // 32 or 64
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;
`ifdef IMM_GEN_ZICSR_EN
    localparam logic [2:0] FMT_Z    = 3'd6;
`endif

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_OPIMM   = 7'b0010011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_FENCE   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OP_OP32    = 7'b0111011;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    // ---------------- combinational decode ----------------
    logic [6:0]  opcode;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] dec_imm32;
    logic [2:0]  dec_fmt;
    logic        dec_illegal;
    entry_t      dec;

    assign opcode = in_instr[6:0];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        dec_imm32   = '0;
        case (opcode)
            OP_LOAD, OP_OPIMM, OP_JALR, OP_FENCE: begin
                dec_fmt   = FMT_I;
                dec_imm32 = imm_i;
            end
            OP_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
                if (in_instr[14]) begin
                    // Bit 31 is zero here, so the common sign-extension below zero-extends zimm.
                    dec_fmt   = FMT_Z;
                    dec_imm32 = {27'b0, in_instr[19:15]};
                end else begin
                    dec_fmt   = FMT_I;
                    dec_imm32 = imm_i;
                end
`else
                dec_fmt   = FMT_I;
                dec_imm32 = imm_i;
`endif
            end
            OP_STORE: begin
                dec_fmt   = FMT_S;
                dec_imm32 = imm_s;
            end
            OP_BRANCH: begin
                dec_fmt   = FMT_B;
                dec_imm32 = imm_b;
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt   = FMT_U;
                dec_imm32 = imm_u;
            end
            OP_JAL: begin
                dec_fmt   = FMT_J;
                dec_imm32 = imm_j;
            end
            OP_OP: begin
                dec_fmt = FMT_R;
            end
            OP_OPIMM32: begin
                if (XLEN == 64) begin
                    dec_fmt   = FMT_I;
                    dec_imm32 = imm_i;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_OP32: begin
                if (XLEN == 64) begin
                    dec_fmt = FMT_R;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Every format fits in 32 bits; widen to XLEN by replicating bit 31.
    always_comb begin
        dec.imm        = {XLEN{dec_imm32[31]}};
        dec.imm[31:0]  = dec_imm32;
        dec.fmt        = dec_fmt;
        dec.illegal    = dec_illegal;
    end

    // ---------------- output register + skid ----------------
    state_t           state_q, state_d;
    entry_t           or_q, or_d;
    entry_t           sk_q, sk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc;

    assign in_ready  = (state_q != ST_SKID);
    assign out_valid = (state_q != ST_EMPTY);
    assign acc       = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        or_d    = or_q;
        sk_d    = sk_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    or_d    = dec;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (acc && out_ready) begin
                    or_d = dec;
                end else if (acc) begin
                    sk_d    = dec;
                    state_d = ST_SKID;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_ready) begin
                    or_d    = sk_q;
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (acc && dec.illegal && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Flush discards everything, including whatever was accepted this cycle.
        if (flush) begin
            state_d = ST_EMPTY;
            or_d    = or_q;
            sk_d    = sk_q;
            cnt_d   = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            or_q.imm    <= '0;
            or_q.fmt    <= FMT_NONE;
            or_q.illegal<= 1'b0;
            sk_q.imm    <= '0;
            sk_q.fmt    <= FMT_NONE;
            sk_q.illegal<= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q <= state_d;
            or_q    <= or_d;
            sk_q    <= sk_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_imm     = or_q.imm;
    assign out_fmt     = or_q.fmt;
    assign out_illegal = or_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench: two instances (XLEN=32/CNT_W=16 and XLEN=64/CNT_W=2) share one stimulus stream.
module tb_imm_gen_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [15:0] cnt32;

    logic        rdy64, vld64, ill64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [1:0]  cnt64;

    int checks = 0;
    int errors = 0;

    imm_gen_stage #(.XLEN(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
        .out_valid(vld32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .illegal_cnt(cnt32)
    );

    imm_gen_stage #(.XLEN(64), .CNT_W(2)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
        .out_valid(vld64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .illegal_cnt(cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one instruction with out_ready=1 and return 1ns after the accepting edge.
    task automatic apply(input logic [31:0] instr);
        @(negedge clk);
        in_valid  = 1'b1;
        in_instr  = instr;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Two entries with out_ready=0 leaves the stage in SKID.
    task automatic fill_skid(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = a;
        @(posedge clk);
        @(negedge clk);
        in_instr = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check_eq("rst_vld",  64'(vld32), 64'h0);
        check_eq("rst_rdy",  64'(rdy32), 64'h1);
        check_eq("rst_imm",  64'(imm32), 64'h0);
        check_eq("rst_fmt",  64'(fmt32), 64'h7);
        check_eq("rst_ill",  64'(ill32), 64'h0);
        check_eq("rst_cnt",  64'(cnt32), 64'h0);

        apply(32'hFFF00093);                       // addi x1,x0,-1
        check_eq("addi_vld",   64'(vld32), 64'h1);
        check_eq("addi_imm",   64'(imm32), 64'hFFFFFFFF);
        check_eq("addi_fmt",   64'(fmt32), 64'h1);
        check_eq("addi_ill",   64'(ill32), 64'h0);
        check_eq("addi_imm64", imm64,      64'hFFFFFFFF_FFFFFFFF);

        apply(32'hFE112E23);                       // sw
        check_eq("sw_imm", 64'(imm32), 64'hFFFFFFFC);
        check_eq("sw_fmt", 64'(fmt32), 64'h2);
        apply(32'hFE000CE3);                       // beq -8
        check_eq("beq_imm", 64'(imm32), 64'hFFFFFFF8);
        check_eq("beq_fmt", 64'(fmt32), 64'h3);
        apply(32'h0080006F);                       // jal +8
        check_eq("jal_imm", 64'(imm32), 64'h00000008);
        check_eq("jal_fmt", 64'(fmt32), 64'h5);
        apply(32'h800002B7);                       // lui
        check_eq("lui_imm",   64'(imm32), 64'h80000000);
        check_eq("lui_fmt",   64'(fmt32), 64'h4);
        check_eq("lui_imm64", imm64,      64'hFFFFFFFF_80000000);
        apply(32'h002081B3);                       // add
        check_eq("add_fmt", 64'(fmt32), 64'h0);
        check_eq("add_imm", 64'(imm32), 64'h0);

        apply(32'h0000007F);                       // illegal
        check_eq("ill_flag",  64'(ill32), 64'h1);
        check_eq("ill_imm",   64'(imm32), 64'h0);
        check_eq("ill_fmt",   64'(fmt32), 64'h7);
        check_eq("ill_cnt",   64'(cnt32), 64'h1);
        check_eq("ill_cnt64", 64'(cnt64), 64'h1);

        apply(32'hFFF0809B);                       // addiw: illegal at 32, I at 64
        check_eq("addiw_ill32", 64'(ill32), 64'h1);
        check_eq("addiw_fmt32", 64'(fmt32), 64'h7);
        check_eq("addiw_ill64", 64'(ill64), 64'h0);
        check_eq("addiw_fmt64", 64'(fmt64), 64'h1);
        check_eq("addiw_imm64", imm64,      64'hFFFFFFFF_FFFFFFFF);
        check_eq("addiw_cnt32", 64'(cnt32), 64'h2);
        check_eq("addiw_cnt64", 64'(cnt64), 64'h1);

        apply(32'h3052D073);                       // csrrwi x0,0x305,5
`ifdef IMM_GEN_ZICSR_EN
        check_eq("csri_fmt", 64'(fmt32), 64'h6);
        check_eq("csri_imm", 64'(imm32), 64'h5);
`else
        check_eq("csri_fmt", 64'(fmt32), 64'h1);
        check_eq("csri_imm", 64'(imm32), 64'h305);
`endif

        for (int k = 0; k < 4; k++) apply(32'h0000007F);
        check_eq("sat_cnt32", 64'(cnt32), 64'h6);
        check_eq("sat_cnt64", 64'(cnt64), 64'h3);

        drain();
        check_eq("drain_vld", 64'(vld32), 64'h0);

        // Backpressure: A accepted, B into skid, C stalls until released.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093;
        @(posedge clk); #1;
        check_eq("bp_a_vld", 64'(vld32), 64'h1);
        check_eq("bp_a_rdy", 64'(rdy32), 64'h1);
        @(negedge clk); in_instr = 32'h00200093;
        @(posedge clk); #1;
        check_eq("bp_b_rdy", 64'(rdy32), 64'h0);
        check_eq("bp_b_imm", 64'(imm32), 64'h1);
        @(negedge clk); in_instr = 32'h00300093;
        @(posedge clk); #1;
        check_eq("bp_c_rdy",  64'(rdy32), 64'h0);
        check_eq("bp_hold",   64'(imm32), 64'h1);
        @(negedge clk); out_ready = 1'b1;
        check_eq("bp_out_a", 64'(imm32), 64'h1);
        @(posedge clk); #1;
        check_eq("bp_out_b",  64'(imm32), 64'h2);
        check_eq("bp_b_vld",  64'(vld32), 64'h1);
        check_eq("bp_rdy_up", 64'(rdy32), 64'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("bp_out_c", 64'(imm32), 64'h3);
        check_eq("bp_c_vld", 64'(vld32), 64'h1);
        @(posedge clk); #1;
        check_eq("bp_empty", 64'(vld32), 64'h0);

        // Flush from SKID.
        fill_skid(32'h00100093, 32'h00200093);
        check_eq("fl_skid_rdy", 64'(rdy32), 64'h0);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check_eq("fl_vld", 64'(vld32), 64'h0);
        check_eq("fl_rdy", 64'(rdy32), 64'h1);
        check_eq("fl_cnt", 64'(cnt32), 64'h6);

        // Flush discards a same-cycle illegal transfer without counting it.
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0000007F; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check_eq("fl_in_vld", 64'(vld32), 64'h0);
        check_eq("fl_in_cnt", 64'(cnt32), 64'h6);

        apply(32'h00100093);
        check_eq("post_fl_imm", 64'(imm32), 64'h1);
        drain();

        // Reset from SKID.
        fill_skid(32'h0000007F, 32'h00200093);
        check_eq("rs_skid_rdy", 64'(rdy32), 64'h0);
        check_eq("rs_pre_cnt",  64'(cnt32), 64'h7);
        @(negedge clk); rst = 1'b1; flush = 1'b1;
        @(posedge clk); #1; rst = 1'b0; flush = 1'b0;
        check_eq("rs_vld",   64'(vld32), 64'h0);
        check_eq("rs_rdy",   64'(rdy32), 64'h1);
        check_eq("rs_cnt",   64'(cnt32), 64'h0);
        check_eq("rs_cnt64", 64'(cnt64), 64'h0);
        check_eq("rs_fmt",   64'(fmt32), 64'h7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, handshaked immediate generator for the Instruction Decode stage. Takes a raw 32-bit instruction, classifies its RISC-V format and produces the XLEN-wide sign-extended immediate.
- Generalises the combinational immediate extender:
  - extracts fields directly from the instruction, with correct I/S/B/U/J bit scrambling;
  - XLEN is parametrised (32 or 64);
  - adds a valid/ready pipeline stage with a skid buffer;
  - flags illegal opcodes and counts them.

Parameters:
- XLEN, 32, datapath width of the immediate; legal values 32 or 64.
- CNT_W, 16, width of the saturating illegal-opcode counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush; drops all held entries.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  raw instruction word.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts the output entry.
- out_imm  out  XLEN  sign/zero-extended immediate.
- out_fmt  out  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z (CSR zimm), 7=NONE.
- out_illegal  out  1  opcode not recognised.
- illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted.

Behaviour:
- Reset (rst=1 at clock edge), all state cleared:
  - out_valid=0, in_ready=1 (from the next cycle), out_imm=0, out_fmt=7, out_illegal=0, illegal_cnt=0, skid empty.
  - Reset overrides flush and any handshake in the same cycle.
- Decode is combinational on in_instr (i = in_instr). opcode i[6:0]; "sx(v)" = sign-extend v to XLEN.
  - I format: 0000011 load, 0010011 op-imm, 1100111 jalr, 0001111 fence, 1110011 system. imm = sx(i[31:20]).
  - S format: 0100011. imm = sx({i[31:25], i[11:7]}).
  - B format: 1100011. imm = sx({i[31], i[7], i[30:25], i[11:8], 1'b0}).
  - U format: 0110111, 0010111. imm = sx({i[31:12], 12'b0}). At XLEN=64, bits 63:32 are copies of i[31].
  - J format: 1101111. imm = sx({i[31], i[19:12], i[20], i[30:21], 1'b0}).
  - R format: 0110011. imm = 0.
  - XLEN=64 only: 0011011 (op-imm-32) is I format; 0111011 (op-32) is R format. At XLEN=32 both are illegal.
  - Any other opcode: fmt=7, imm=0, illegal=1.
- Handshake:
  - Transfer on the input when in_valid & in_ready; on the output when out_valid & out_ready.
  - in_ready is a register: in_ready = !skid_valid. It does not depend combinationally on out_ready.
  - Latency: exactly 1 cycle from input transfer to out_valid when the stage is empty.
  - Full throughput (1 instruction/cycle) while out_ready=1.
- State machine (output register OR + skid register SK):
  - EMPTY:
    - accept -> FULL (OR loaded).
  - FULL:
    - accept with out_ready=1 -> FULL (OR replaced).
    - out_ready=1 with no accept -> EMPTY.
    - accept with out_ready=0 -> SKID (new entry held in SK).
  - SKID (in_ready=0):
    - out_ready=1 -> FULL, with OR <= SK.
  - Entries leave in strict acceptance order; no entry is dropped or duplicated.
  - Output registers hold stable while out_valid & !out_ready.
- flush: next state EMPTY; the same-cycle input transfer is discarded and illegal_cnt is not incremented for it.
- illegal_cnt:
  - Increments by 1 on each accepted (non-flushed) instruction with illegal=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by rst.
- Once a flush or reset completes, in_ready=1.

Optional Feature:
- Macro: IMM_GEN_ZICSR_EN.
- Defined: opcode 1110011 with i[14]=1 (csrrwi/csrrsi/csrrci) gives fmt=6 and imm = zero-extension of i[19:15]. Other SYSTEM encodings stay I format.
- Undefined: all 1110011 instructions are I format; fmt code 6 is never produced.

Test Plan:
- addi 0xFFF00093, XLEN=32 -> one cycle later out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_illegal=0.
- sw 0xFE112E23 -> imm 0xFFFFFFFC, fmt=2. beq 0xFE000CE3 -> imm 0xFFFFFFF8, fmt=3. jal 0x0080006F -> imm 0x00000008, fmt=5.
- lui 0x800002B7: XLEN=32 -> imm 0x80000000, fmt=4. XLEN=64 -> imm 0xFFFFFFFF80000000.
- Backpressure: hold out_ready=0 and present 3 back-to-back instructions -> first two accepted, in_ready=0 from the cycle after the second. Raise out_ready -> the three are delivered in order on consecutive cycles, none lost.
- Illegal 0x0000007F -> out_illegal=1, imm 0, fmt=7, illegal_cnt 0->1. With CNT_W=2, 5 illegal instructions -> illegal_cnt stays at 3.
- Assert rst (and separately flush) with the stage in SKID -> next cycle out_valid=0, in_ready=1. For rst, illegal_cnt=0; for flush, illegal_cnt is unchanged.
